// File: rtl/servo_slew_scheduler.sv
// Round-robin scheduler that hands one enabled servo at a time to the duty mux and slews its duty toward target once per PWM period.
// Optional per-servo watchdog is compiled in with `define SERVO_WATCHDOG_EN.
module servo_slew_scheduler #(
  parameter int DUTY_W      = 21,
  parameter int DUTY_MIN    = 100000,
  parameter int DUTY_MAX    = 200000,
  parameter int DUTY_INIT   = 150000,
  parameter int DUTY_STEP   = 1000,
  parameter int TIMEOUT_CYC = 2500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        Enable,
  input  logic              WrEn,
  input  logic [1:0]        WrAddr,
  input  logic [DUTY_W-1:0] WrData,
  input  logic              ActivePeriodFinished,
  output logic [1:0]        ServoNum,
  output logic [DUTY_W-1:0] ActiveServoDuty,
  output logic              Busy,
  output logic              Settled,
  output logic [3:0]        Fault
);

  typedef enum logic [1:0] {StIdle, StSelect, StWait, StUpdate} stateT;

  localparam logic [DUTY_W-1:0] DutyMin  = DUTY_W'(DUTY_MIN);
  localparam logic [DUTY_W-1:0] DutyMax  = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] DutyInit = DUTY_W'(DUTY_INIT);
  localparam logic [DUTY_W-1:0] DutyStep = DUTY_W'(DUTY_STEP);
  localparam logic signed [DUTY_W:0] StepS = $signed({1'b0, DutyStep});

  stateT state, stateNext;
  logic [1:0] ptr, sel, selScan;
  logic selFound;
  logic prevPf, risingPf, timeout, wdExpire, settledNext;
  logic [DUTY_W-1:0] target [4];
  logic [DUTY_W-1:0] current [4];
  logic [DUTY_W-1:0] wrClamped, stepped;
  logic signed [DUTY_W:0] diff;

  // Scan starts just past the last serviced servo so every enabled channel gets a fair turn.
  always_comb begin
    selScan  = ptr;
    selFound = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!selFound && Enable[ptr + 2'(k)]) begin
        selScan  = ptr + 2'(k);
        selFound = 1'b1;
      end
    end
  end

  always_comb begin
    wrClamped = WrData;
    if (WrData < DutyMin)      wrClamped = DutyMin;
    else if (WrData > DutyMax) wrClamped = DutyMax;
  end

  always_comb begin
    diff = $signed({1'b0, target[sel]}) - $signed({1'b0, current[sel]});
    if (diff > StepS)       stepped = current[sel] + DutyStep;
    else if (diff < -StepS) stepped = current[sel] - DutyStep;
    else                    stepped = target[sel];
  end

  assign risingPf = ActivePeriodFinished && !prevPf;
  assign wdExpire = (state == StWait) && Enable[sel] && !risingPf && timeout;
  assign Busy     = (state != StIdle);

  always_comb begin
    settledNext = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (Enable[i] && (current[i] != target[i])) settledNext = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= StIdle;
    else       state <= stateNext;
  end

  // A disabled servo abandons its slot before any period edge is honoured.
  always_comb begin
    stateNext = state;
    case (state)
      StIdle:   if (Enable != 4'b0000) stateNext = StSelect;
      StSelect: stateNext = StWait;
      StWait: begin
        if (!Enable[sel])  stateNext = StIdle;
        else if (risingPf) stateNext = StUpdate;
        else if (timeout)  stateNext = StIdle;
      end
      StUpdate: stateNext = StIdle;
      default:  stateNext = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr             <= 2'd3;
      sel             <= 2'd0;
      prevPf          <= 1'b0;
      ServoNum        <= 2'd0;
      ActiveServoDuty <= DutyInit;
      Settled         <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        target[i]  <= DutyInit;
        current[i] <= DutyInit;
      end
    end else begin
      if (WrEn) target[WrAddr] <= wrClamped;
      Settled <= settledNext;
      case (state)
        StIdle: if (Enable != 4'b0000) sel <= selScan;
        StSelect: begin
          ServoNum        <= sel;
          ActiveServoDuty <= current[sel];
          prevPf          <= 1'b1;
        end
        StWait: begin
          prevPf <= ActivePeriodFinished;
          if (wdExpire) ptr <= sel;
        end
        StUpdate: begin
          current[sel] <= stepped;
          ptr          <= sel;
        end
        default: ;
      endcase
    end
  end

`ifdef SERVO_WATCHDOG_EN
  localparam int WdW = $clog2(TIMEOUT_CYC);
  logic [WdW-1:0] wdCnt;
  logic [3:0] faultQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      wdCnt  <= '0;
      faultQ <= 4'b0000;
    end else begin
      if (state == StSelect)    wdCnt <= '0;
      else if (state == StWait) wdCnt <= wdCnt + 1'b1;
      if (wdExpire) faultQ[sel] <= 1'b1;
    end
  end

  assign timeout = (wdCnt == WdW'(TIMEOUT_CYC - 1));
  assign Fault   = faultQ;
`else
  // Without the watchdog the limit has no effect; it is sunk here so the parameter stays referenced.
  logic unusedTimeout;
  assign unusedTimeout = ^TIMEOUT_CYC;
  assign timeout       = 1'b0;
  assign Fault         = 4'b0000;
`endif

endmodule

// File: tb/tb_servo_slew_scheduler.sv
// Self-checking bench for servo_slew_scheduler: expected (servo, duty) per serviced slot is queued and popped when the slot appears.
module tb_servo_slew_scheduler;
  localparam int DW = 21;
  typedef struct packed {
    logic [1:0]    servo;
    logic [DW-1:0] duty;
  } slotT;

  logic          clk = 1'b0;
  logic          reset, WrEn, ActivePeriodFinished;
  logic [3:0]    Enable;
  logic [1:0]    WrAddr;
  logic [DW-1:0] WrData;
  logic [1:0]    ServoNum;
  logic [DW-1:0] ActiveServoDuty;
  logic          Busy, Settled;
  logic [3:0]    Fault;

  int compared   = 0;
  int mismatched = 0;
  slotT sb[$];
  logic [DW-1:0] mTarget [4];
  logic [DW-1:0] mCurrent [4];
  logic [1:0]    mPtr;

  servo_slew_scheduler dut (
    .clk(clk), .reset(reset), .Enable(Enable), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .ActivePeriodFinished(ActivePeriodFinished), .ServoNum(ServoNum), .ActiveServoDuty(ActiveServoDuty),
    .Busy(Busy), .Settled(Settled), .Fault(Fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL global timeout: still running at 200000 ns, required to finish earlier");
    $fatal(1, "[TB] run aborted");
  end

  function automatic logic [DW-1:0] mClamp(input int v);
    if (v < 100000) return 21'd100000;
    if (v > 200000) return 21'd200000;
    return DW'(v);
  endfunction

  function automatic logic [DW-1:0] mStep(input logic [DW-1:0] cur, input logic [DW-1:0] tgt);
    int d;
    d = int'(tgt) - int'(cur);
    if (d > 1000)  return cur + 21'd1000;
    if (d < -1000) return cur - 21'd1000;
    return tgt;
  endfunction

  function automatic logic [1:0] mNextSel(input logic [3:0] en);
    logic [1:0] idx;
    for (int k = 1; k <= 4; k++) begin
      idx = mPtr + 2'(k);
      if (en[idx]) return idx;
    end
    return mPtr;
  endfunction

  function automatic logic mSettled(input logic [3:0] en);
    for (int i = 0; i < 4; i++) if (en[i] && mCurrent[i] != mTarget[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1; Enable = 4'b0000; WrEn = 1'b0; WrAddr = 2'd0; WrData = '0; ActivePeriodFinished = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mTarget[i]  = 21'd150000;
      mCurrent[i] = 21'd150000;
    end
    mPtr = 2'd3;
    sb.delete();
  endtask

  task automatic writeTarget(input logic [1:0] a, input int v);
    WrEn = 1'b1; WrAddr = a; WrData = DW'(v);
    tick();
    WrEn = 1'b0;
    mTarget[a] = mClamp(v);
  endtask

  task automatic pulsePf();
    ActivePeriodFinished = 1'b0;
    tick();
    ActivePeriodFinished = 1'b1;
    tick();
    ActivePeriodFinished = 1'b0;
    tick();
  endtask

  // Waits (bounded) for the next SELECT, steps into WAIT and captures the mux outputs.
  task automatic observeSlot(output bit ok, output slotT exp, output slotT obs, output logic settled);
    int n;
    n  = 0;
    ok = 1'b0;
    while (Busy !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (Busy === 1'b1) begin
      tick();
      ok = 1'b1;
    end
    obs     = '{servo: ServoNum, duty: ActiveServoDuty};
    settled = Settled;
    if (sb.size() > 0) exp = sb.pop_front();
    else               exp = 'x;
  endtask

  task automatic test_reset();
    doReset();
    compared++; if (ServoNum !== 2'd0) begin mismatched++; $display("[TB] FAIL reset ServoNum: got %0d, need 0", ServoNum); end
    compared++; if (ActiveServoDuty !== 21'd150000) begin mismatched++; $display("[TB] FAIL reset duty: got %0d, need 150000", ActiveServoDuty); end
    compared++; if (Busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset Busy: got %b, need 0", Busy); end
    compared++; if (Settled !== 1'b1) begin mismatched++; $display("[TB] FAIL reset Settled: got %b, need 1", Settled); end
    compared++; if (Fault !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset Fault: got %b, need 0000", Fault); end
    writeTarget(2'd0, 170000);
    repeat (2) tick();
    compared++; if (Settled !== 1'b1 || Busy !== 1'b0) begin mismatched++; $display("[TB] FAIL idle disabled: got Settled %b Busy %b, need 1 0", Settled, Busy); end
    Enable = 4'b0001;
    repeat (2) tick();
    compared++; if (Settled !== 1'b0) begin mismatched++; $display("[TB] FAIL enabled unsettled: got Settled %b, need 0", Settled); end
  endtask

  task automatic test_slew();
    logic [DW-1:0] dutyTab [5];
    bit ok; slotT e, o; logic st;
    dutyTab = '{21'd150000, 21'd151000, 21'd152000, 21'd153000, 21'd153500};
    doReset();
    writeTarget(2'd0, 153500);
    Enable = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{2'd0, dutyTab[i]});
      observeSlot(ok, e, o, st);
      compared++;
      if (!ok || o !== e) begin mismatched++; $display("[TB] FAIL slew slot %0d: got servo %0d duty %0d (ok %b), need servo %0d duty %0d", i, o.servo, o.duty, ok, e.servo, e.duty); end
      if (i < 4) pulsePf();
      if (i == 3) begin
        compared++; if (Settled !== 1'b0) begin mismatched++; $display("[TB] FAIL slew settled lag: got %b at last update, need 0", Settled); end
        tick();
        compared++; if (Settled !== 1'b1) begin mismatched++; $display("[TB] FAIL slew settled rise: got %b one cycle later, need 1", Settled); end
      end
    end
    pulsePf();
  endtask

  task automatic test_round_robin();
    logic [1:0]    servoTab [5];
    logic [DW-1:0] dutyTab [5];
    bit ok; slotT e, o; logic st;
    servoTab = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1};
    dutyTab  = '{21'd150000, 21'd150000, 21'd150000, 21'd150000, 21'd151000};
    doReset();
    writeTarget(2'd1, 160000);
    Enable = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{servoTab[i], dutyTab[i]});
      observeSlot(ok, e, o, st);
      compared++;
      if (!ok || o !== e) begin mismatched++; $display("[TB] FAIL round-robin slot %0d: got servo %0d duty %0d (ok %b), need servo %0d duty %0d", i, o.servo, o.duty, ok, e.servo, e.duty); end
      pulsePf();
    end
  endtask

  task automatic test_clamp();
    bit ok; slotT e, o; logic st, expSet;
    logic [1:0] s;
    logic [DW-1:0] lastDuty [4];
    int changes [4];
    doReset();
    writeTarget(2'd2, 300000);
    writeTarget(2'd1, 5000);
    Enable = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      lastDuty[i] = 21'd150000;
      changes[i]  = 0;
    end
    for (int i = 0; i < 102; i++) begin
      s = mNextSel(Enable);
      sb.push_back('{s, mCurrent[s]});
      expSet = mSettled(Enable);
      observeSlot(ok, e, o, st);
      compared++;
      if (!ok || o !== e) begin mismatched++; $display("[TB] FAIL clamp slot %0d: got servo %0d duty %0d (ok %b), need servo %0d duty %0d", i, o.servo, o.duty, ok, e.servo, e.duty); end
      compared++;
      if (st !== expSet) begin mismatched++; $display("[TB] FAIL clamp settled slot %0d: got %b, need %b", i, st, expSet); end
      if (o.duty !== lastDuty[o.servo]) changes[o.servo]++;
      lastDuty[o.servo] = o.duty;
      pulsePf();
      mCurrent[s] = mStep(mCurrent[s], mTarget[s]);
      mPtr = s;
    end
    compared++; if (changes[1] != 50 || changes[2] != 50) begin mismatched++; $display("[TB] FAIL clamp update count: got %0d and %0d, need 50 and 50", changes[1], changes[2]); end
    compared++; if (lastDuty[2] !== 21'd200000) begin mismatched++; $display("[TB] FAIL clamp high: got %0d, need 200000", lastDuty[2]); end
    compared++; if (lastDuty[1] !== 21'd100000) begin mismatched++; $display("[TB] FAIL clamp low: got %0d, need 100000", lastDuty[1]); end
    compared++; if (Fault !== 4'b0000) begin mismatched++; $display("[TB] FAIL fault tied: got %b, need 0000", Fault); end
  endtask

  task automatic test_stale_flag();
    bit ok, stayed; slotT e, o; logic st;
    doReset();
    writeTarget(2'd0, 160000);
    ActivePeriodFinished = 1'b1;
    Enable = 4'b0001;
    sb.push_back('{2'd0, 21'd150000});
    observeSlot(ok, e, o, st);
    compared++;
    if (!ok || o !== e) begin mismatched++; $display("[TB] FAIL stale entry: got servo %0d duty %0d (ok %b), need servo %0d duty %0d", o.servo, o.duty, ok, e.servo, e.duty); end
    stayed = 1'b1;
    repeat (5) begin
      tick();
      if (Busy !== 1'b1) stayed = 1'b0;
    end
    compared++; if (!stayed) begin mismatched++; $display("[TB] FAIL stale flag: got an early exit from WAIT, need Busy held for 5 cycles"); end
    pulsePf();
    sb.push_back('{2'd0, 21'd151000});
    observeSlot(ok, e, o, st);
    compared++;
    if (!ok || o !== e) begin mismatched++; $display("[TB] FAIL stale single update: got servo %0d duty %0d (ok %b), need servo %0d duty %0d", o.servo, o.duty, ok, e.servo, e.duty); end
  endtask

  task automatic test_abort();
    slotT expTab [4];
    bit ok; slotT e, o; logic st;
    expTab = '{'{2'd0, 21'd150000}, '{2'd1, 21'd150000}, '{2'd1, 21'd150000}, '{2'd0, 21'd151000}};
    doReset();
    writeTarget(2'd0, 160000);
    writeTarget(2'd1, 170000);
    Enable = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(expTab[i]);
      observeSlot(ok, e, o, st);
      compared++;
      if (!ok || o !== e) begin mismatched++; $display("[TB] FAIL abort slot %0d: got servo %0d duty %0d (ok %b), need servo %0d duty %0d", i, o.servo, o.duty, ok, e.servo, e.duty); end
      if (i == 1) begin
        Enable = 4'b0001;
        tick();
        compared++; if (Busy !== 1'b0) begin mismatched++; $display("[TB] FAIL abort to idle: got Busy %b, need 0", Busy); end
        Enable = 4'b0011;
      end else begin
        pulsePf();
      end
    end
  endtask

  task automatic test_write_collision();
    bit ok; slotT e, o; logic st;
    doReset();
    Enable = 4'b0001;
    sb.push_back('{2'd0, 21'd150000});
    sb.push_back('{2'd0, 21'd150000});
    sb.push_back('{2'd0, 21'd151000});
    for (int i = 0; i < 3; i++) begin
      observeSlot(ok, e, o, st);
      compared++;
      if (!ok || o !== e) begin mismatched++; $display("[TB] FAIL collision slot %0d: got servo %0d duty %0d (ok %b), need servo %0d duty %0d", i, o.servo, o.duty, ok, e.servo, e.duty); end
      if (i == 0) begin
        ActivePeriodFinished = 1'b0;
        tick();
        ActivePeriodFinished = 1'b1;
        tick();
        ActivePeriodFinished = 1'b0;
        WrEn = 1'b1; WrAddr = 2'd0; WrData = 21'd160000;
        tick();
        WrEn = 1'b0;
      end else begin
        pulsePf();
      end
    end
  endtask

  task automatic test_reset_midop();
    bit ok; slotT e, o; logic st;
    doReset();
    writeTarget(2'd2, 180000);
    Enable = 4'b0100;
    sb.push_back('{2'd2, 21'd150000});
    sb.push_back('{2'd2, 21'd151000});
    for (int i = 0; i < 2; i++) begin
      observeSlot(ok, e, o, st);
      compared++;
      if (!ok || o !== e) begin mismatched++; $display("[TB] FAIL pre-reset slot %0d: got servo %0d duty %0d (ok %b), need servo %0d duty %0d", i, o.servo, o.duty, ok, e.servo, e.duty); end
      if (i == 0) pulsePf();
    end
    reset = 1'b1;
    tick();
    compared++; if (ServoNum !== 2'd0 || ActiveServoDuty !== 21'd150000) begin mismatched++; $display("[TB] FAIL mid reset outputs: got servo %0d duty %0d, need 0 150000", ServoNum, ActiveServoDuty); end
    compared++; if (Busy !== 1'b0 || Settled !== 1'b1) begin mismatched++; $display("[TB] FAIL mid reset flags: got Busy %b Settled %b, need 0 1", Busy, Settled); end
    reset = 1'b0;
    sb.push_back('{2'd2, 21'd150000});
    sb.push_back('{2'd2, 21'd150000});
    for (int i = 0; i < 2; i++) begin
      observeSlot(ok, e, o, st);
      compared++;
      if (!ok || o !== e) begin mismatched++; $display("[TB] FAIL post-reset slot %0d: got servo %0d duty %0d (ok %b), need servo %0d duty %0d", i, o.servo, o.duty, ok, e.servo, e.duty); end
      compared++;
      if (st !== 1'b1) begin mismatched++; $display("[TB] FAIL post-reset settled %0d: got %b, need 1", i, st); end
      pulsePf();
    end
  endtask

  initial begin
    reset = 1'b1; Enable = 4'b0000; WrEn = 1'b0; WrAddr = 2'd0; WrData = '0; ActivePeriodFinished = 1'b0;
    $display("[TB] starting servo_slew_scheduler bench");
    test_reset();
    test_slew();
    test_round_robin();
    test_clamp();
    test_stale_flag();
    test_abort();
    test_write_collision();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
